// File: rtl/spi_adc_pkg.sv
// Shared types and helpers for the multi-channel SPI ADC capture engine.
// Optional feature macro: SPI_ADC_CH_TAG_EN (prefix each FIFO word with its channel index).
package spi_adc_pkg;

    // Capture sequencer states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_WRITE,
        ST_DONE
    } spi_adc_state_t;

    // SPI mode 0: sclk rests low.
    localparam logic SCLK_IDLE = 1'b0;

`ifdef SPI_ADC_CH_TAG_EN
    localparam bit CH_TAG_EN = 1'b1;
`else
    localparam bit CH_TAG_EN = 1'b0;
`endif

    // Width of a channel index; never narrower than one bit.
    function automatic int spi_adc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Width of one FIFO word: the sample, optionally prefixed by the channel index.
    function automatic int spi_adc_word_w(input int data_w, input int num_ch);
        return data_w + (CH_TAG_EN ? spi_adc_ch_w(num_ch) : 0);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head entry is always visible
// on dout while the FIFO is not empty; pop advances to the next entry.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));
    // Empty FIFO presents zero rather than stale storage.
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array; contents are only meaningful below the level, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/spi_adc_mc_fifo.sv
// Multi-channel SPI ADC capture engine with sample FIFO. One shared cs_n/sclk
// pair (mode 0) clocks NUM_CH simultaneously-sampling ADCs; each frame stores
// one sample per channel, in channel order, or drops the whole frame if the
// FIFO cannot take all of it.
// Optional feature macro: SPI_ADC_CH_TAG_EN (FIFO word = {channel index, sample}).
module spi_adc_mc_fifo
    import spi_adc_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 4,
    localparam int WORD_W    = spi_adc_word_w(DATA_W, NUM_CH),
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_sample,
    input  logic              cont,
    input  logic [NUM_CH-1:0] din,
    input  logic              fifo_pop,
    input  logic              clr_ovf,
    output logic              cs_n,
    output logic              sclk,
    output logic              ready,
    output logic              done,
    output logic [WORD_W-1:0] fifo_dout,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow
);

    localparam int CH_W   = spi_adc_ch_w(NUM_CH);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int HALF_W = $clog2(2 * DATA_W);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(2 * DATA_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(NUM_CH - 1);
    // Largest level that still leaves room for a whole frame.
    localparam logic [LVL_W-1:0]  ACCEPT_MAX = LVL_W'(FIFO_DEPTH - NUM_CH);

    spi_adc_state_t    state;
    logic [DIV_W-1:0]  div_cnt;
    logic [HALF_W-1:0] half_cnt;
    logic [CH_W-1:0]   ch_cnt;
    logic [DATA_W-1:0] shreg [NUM_CH];
    logic              div_tick;
    logic              write_ok;
    logic              push;
    logic [WORD_W-1:0] push_data;

    assign div_tick = (div_cnt == DIV_LAST);

    // The space test happens on the first WRITE cycle (ch_cnt still 0). Once a
    // frame is accepted, ch_cnt > 0 keeps it accepted; pops during WRITE only
    // add space, so the remaining writes cannot overrun.
    assign write_ok = (ch_cnt != '0) || (fifo_level <= ACCEPT_MAX);
    assign push     = (state == ST_WRITE) && write_ok;

`ifdef SPI_ADC_CH_TAG_EN
    assign push_data = {ch_cnt, shreg[ch_cnt]};
`else
    assign push_data = shreg[ch_cnt];
`endif

    // Frame sequencer with registered cs_n/sclk/ready/done/overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cs_n     <= 1'b1;
            sclk     <= SCLK_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            ch_cnt   <= '0;
        end else begin
            done <= 1'b0;
            // A drop in WRITE below overrides this clear in the same cycle.
            if (clr_ovf) begin
                overflow <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start_sample) begin
                        state   <= ST_CS_SETUP;
                        cs_n    <= 1'b0;
                        ready   <= 1'b0;
                        div_cnt <= '0;
                    end
                end
                ST_CS_SETUP: begin
                    if (div_tick) begin
                        div_cnt  <= '0;
                        half_cnt <= '0;
                        state    <= ST_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // One half sclk period per CLK_DIV cycles; the final
                    // half period ends on the last falling edge.
                    if (div_tick) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (half_cnt == HALF_LAST) begin
                            state <= ST_CS_HOLD;
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_CS_HOLD: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        ch_cnt  <= '0;
                        state   <= ST_WRITE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!write_ok) begin
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else if (ch_cnt == CH_LAST) begin
                        ch_cnt <= '0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        ch_cnt <= ch_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (cont) begin
                        state   <= ST_CS_SETUP;
                        cs_n    <= 1'b0;
                        div_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cs_n  <= 1'b1;
                    sclk  <= SCLK_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Capture every channel MSB first on the clk edge where sclk rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shreg[i] <= '0;
            end
        end else if ((state == ST_SHIFT) && div_tick && (sclk == 1'b0)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shreg[i] <= {shreg[i][DATA_W-2:0], din[i]};
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .dout      (fifo_dout),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_spi_adc_mc_fifo.sv
// Bench for spi_adc_mc_fifo: NUM_CH=2, DATA_W=16, CLK_DIV=4, FIFO_DEPTH=4.
// ADC behaviour model drives din; expected FIFO words go into exp_q when a
// frame is expected to be stored, and a monitor compares on every real pop.
module tb_spi_adc_mc_fifo;
    import spi_adc_pkg::*;

    localparam int DATA_W     = 16;
    localparam int NUM_CH     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CLK_DIV    = 4;
    localparam int WORD_W     = spi_adc_word_w(DATA_W, NUM_CH);
    localparam int CH_W       = spi_adc_ch_w(NUM_CH);
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    // cs_n fall cycle through done cycle inclusive: 4*(2*16+2) + 2 + 1.
    localparam int FRAME_LEN  = 139;

    logic              clk;
    logic              rst;
    logic              start_sample;
    logic              cont;
    logic [NUM_CH-1:0] din;
    logic              fifo_pop;
    logic              clr_ovf;
    logic              cs_n;
    logic              sclk;
    logic              ready;
    logic              done;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [WORD_W-1:0]          exp_q[$];
    logic [NUM_CH*DATA_W-1:0]   frame_q[$];
    logic [NUM_CH*DATA_W-1:0]   cur_word = '0;
    int                         bit_idx = DATA_W - 1;

    spi_adc_mc_fifo #(
        .DATA_W     (DATA_W),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_sample (start_sample),
        .cont         (cont),
        .din          (din),
        .fifo_pop     (fifo_pop),
        .clr_ovf      (clr_ovf),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .ready        (ready),
        .done         (done),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ADC model ----------------
    // Each ADC presents its MSB when cs_n falls and moves to the next bit on
    // every sclk falling edge.
    always @(negedge cs_n) begin
        if (frame_q.size() > 0) begin
            cur_word = frame_q.pop_front();
        end else begin
            cur_word = '0;
        end
        bit_idx = DATA_W - 1;
    end

    always @(negedge sclk) begin
        if (!cs_n && bit_idx > 0) begin
            bit_idx = bit_idx - 1;
        end
    end

    always_comb begin
        din = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            din[i] = cur_word[i*DATA_W + bit_idx];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [WORD_W-1:0] exp_word(input int ch, input logic [DATA_W-1:0] s);
        logic [WORD_W-1:0] w;
`ifdef SPI_ADC_CH_TAG_EN
        w = {CH_W'(ch), s};
`else
        w = s;
        if (ch < 0) w = '0;
`endif
        return w;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : sb_monitor
        logic [WORD_W-1:0] e;
        if (!rst && fifo_pop && !fifo_empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got 0x%0h expected no word", fifo_dout);
            end else begin
                e = exp_q.pop_front();
                check("sb_word", 32'(fifo_dout), 32'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame(input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] c1,
                              input bit store);
        frame_q.push_back({c1, c0});
        if (store) begin
            exp_q.push_back(exp_word(0, c0));
            exp_q.push_back(exp_word(1, c1));
        end
    endtask

    task automatic start_frame();
        @(posedge clk); #1 start_sample = 1'b1;
        @(posedge clk); #1 start_sample = 1'b0;
    endtask

    task automatic pop_one();
        @(posedge clk); #1 fifo_pop = 1'b1;
        @(posedge clk); #1 fifo_pop = 1'b0;
    endtask

    // Counts negedges until cs_n is low (1 = already low at the next negedge).
    task automatic wait_cs_low(input string name, output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (cs_n === 1'b0) begin
                ok = 1'b1;
                cycles = k;
                break;
            end
        end
        if (!ok) fail_timeout(name);
    endtask

    // Returns 1 ns after the clk edge at which cs_n rose (first WRITE cycle).
    task automatic wait_cs_rise(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (cs_n === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout(name);
    endtask

    // Counts negedges until done is seen high.
    task automatic wait_done(input string name, output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                cycles = k;
                break;
            end
        end
        if (!ok) fail_timeout(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        int m;
        int rises;
        logic prev_s;

        rst = 1'b1;
        start_sample = 1'b0;
        cont = 1'b0;
        fifo_pop = 1'b0;
        clr_ovf = 1'b0;

        // Reset values, sampled while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'(1));
        check("rst_sclk", 32'(sclk), 32'(0));
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_done", 32'(done), 32'(0));
        check("rst_empty", 32'(fifo_empty), 32'(1));
        check("rst_full", 32'(fifo_full), 32'(0));
        check("rst_level", 32'(fifo_level), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_dout", 32'(fifo_dout), 32'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Single frame: ch0 0xABCD, ch1 0x1234.
        push_frame(16'hABCD, 16'h1234, 1'b1);
        start_frame();
        wait_cs_low("t1_cs_fall", n);
        check("t1_cs_latency", 32'(n), 32'(1));
        wait_done("t1_done", m);
        check("t1_frame_len", 32'(m + 1), 32'(FRAME_LEN));
        check("t1_level", 32'(fifo_level), 32'(2));
        check("t1_not_empty", 32'(fifo_empty), 32'(0));
        check("t1_cs_high", 32'(cs_n), 32'(1));
        @(negedge clk);
        check("t1_ready", 32'(ready), 32'(1));
        check("t1_done_pulse", 32'(done), 32'(0));
        pop_one();
        pop_one();
        @(negedge clk);
        check("t1_empty", 32'(fifo_empty), 32'(1));
        check("t1_level0", 32'(fifo_level), 32'(0));

        // Pop on empty FIFO is ignored.
        pop_one();
        @(negedge clk);
        check("t2_level", 32'(fifo_level), 32'(0));
        check("t2_empty", 32'(fifo_empty), 32'(1));

        // Continuous mode: two frames fill the FIFO, the third is dropped while
        // clr_ovf is asserted in the drop cycle.
        cont = 1'b1;
        push_frame(16'h1111, 16'h2222, 1'b1);
        push_frame(16'h3333, 16'h4444, 1'b1);
        push_frame(16'h5555, 16'h6666, 1'b0);
        start_frame();
        wait_done("t3_done1", m);
        check("t3_level1", 32'(fifo_level), 32'(2));
        wait_done("t3_done2", m);
        check("t3_period", 32'(m), 32'(FRAME_LEN));
        check("t3_level2", 32'(fifo_level), 32'(4));
        check("t3_full", 32'(fifo_full), 32'(1));
        check("t3_ovf_pre", 32'(overflow), 32'(0));
        wait_cs_rise("t3_write3");
        check("t3_ovf_write", 32'(overflow), 32'(0));
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        check("t3_drop_done", 32'(done), 32'(1));
        check("t3_ovf_set_wins", 32'(overflow), 32'(1));
        check("t3_level_kept", 32'(fifo_level), 32'(4));
        cont = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_idle", 32'(ready), 32'(1));
        check("t3_ovf_sticky", 32'(overflow), 32'(1));
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        @(negedge clk);
        check("t3_ovf_clear", 32'(overflow), 32'(0));
        repeat (4) pop_one();
        @(negedge clk);
        check("t3_empty", 32'(fifo_empty), 32'(1));

        // Pop during WRITE with level 2: frame accepted, push+pop keep level.
        push_frame(16'h7777, 16'h8888, 1'b1);
        start_frame();
        wait_done("t4_done1", m);
        check("t4_level_pre", 32'(fifo_level), 32'(2));
        push_frame(16'h9999, 16'hAAAA, 1'b1);
        start_frame();
        wait_cs_low("t4_cs_fall", n);
        wait_cs_rise("t4_write");
        check("t4_level_entry", 32'(fifo_level), 32'(2));
        fifo_pop = 1'b1;
        @(posedge clk); #1;
        fifo_pop = 1'b0;
        check("t4_push_pop_same", 32'(fifo_level), 32'(2));
        @(posedge clk); #1;
        check("t4_done", 32'(done), 32'(1));
        check("t4_level_post", 32'(fifo_level), 32'(3));
        check("t4_ovf", 32'(overflow), 32'(0));
        repeat (3) pop_one();
        @(negedge clk);
        check("t4_empty", 32'(fifo_empty), 32'(1));

        // Reset in the middle of SHIFT, at bit 7, with a stored frame present.
        push_frame(16'hDEAD, 16'hBEEF, 1'b0);
        start_frame();
        wait_done("t5_done1", m);
        check("t5_level_pre", 32'(fifo_level), 32'(2));
        push_frame(16'hF00D, 16'hCAFE, 1'b0);
        start_frame();
        wait_cs_low("t5_cs_fall", n);
        rises = 0;
        prev_s = sclk;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (sclk && !prev_s) rises++;
            prev_s = sclk;
            if (rises == 8) break;
        end
        if (rises != 8) fail_timeout("t5_sclk_rises");
        #2 rst = 1'b1;
        #1;
        check("t5_rst_cs_n", 32'(cs_n), 32'(1));
        check("t5_rst_sclk", 32'(sclk), 32'(0));
        check("t5_rst_level", 32'(fifo_level), 32'(0));
        check("t5_rst_empty", 32'(fifo_empty), 32'(1));
        check("t5_rst_ready", 32'(ready), 32'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Clean capture after the aborted frame.
        push_frame(16'h5A5A, 16'hC3C3, 1'b1);
        start_frame();
        wait_cs_low("t6_cs_fall", n);
        wait_done("t6_done", m);
        check("t6_frame_len", 32'(m + 1), 32'(FRAME_LEN));
        check("t6_level", 32'(fifo_level), 32'(2));
        pop_one();
        pop_one();
        @(negedge clk);
        check("t6_empty", 32'(fifo_empty), 32'(1));

        repeat (5) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Overall time bound in case the DUT never answers.
    initial begin : watchdog
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
